// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed dual-digit hex 7-segment driver with per-frame value latch
module seg7_scan #(
  parameter int REFRESH_CYCLES = 12000,
  parameter int DEAD_CYCLES = 64,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] value_i,
  input  logic       lzb_i,
  input  logic       blank_i,
  output logic [6:0] seg_o,
  output logic       digit_sel_o
);
  localparam int MAX_CYCLES = REFRESH_CYCLES > DEAD_CYCLES ? REFRESH_CYCLES : DEAD_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] SHOW_LOAD = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);
  localparam logic [6:0] POL = {7{ACTIVE_LOW}};
  typedef enum logic [1:0] {SHOW_LO, DEAD_A, SHOW_HI, DEAD_B} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] shadow, shadow_n;
  logic lzb, lzb_n, load, show_n, lit_n, sel_n;
  logic [3:0] nib_n;
  logic [6:0] seg_n;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction
  always_comb begin
    state_n = cnt == '0 ? state_t'(state + 2'd1) : state;
    show_n = state_n == SHOW_LO || state_n == SHOW_HI;
    cnt_n = cnt == '0 ? (show_n ? SHOW_LOAD : DEAD_LOAD) : cnt - CW'(1);
    load = state == DEAD_B && cnt == '0;
    shadow_n = load ? value_i : shadow;
    lzb_n = load ? lzb_i : lzb;
    nib_n = state_n == SHOW_HI ? shadow_n[7:4] : shadow_n[3:0];
    lit_n = show_n && !blank_i && !(state_n == SHOW_HI && lzb_n && shadow_n[7:4] == 4'd0);
    seg_n = lit_n ? decode(nib_n) : 7'd0;
    sel_n = state_n == SHOW_LO ? 1'b0 : state_n == SHOW_HI ? 1'b1 : digit_sel_o;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= DEAD_B;
      cnt <= DEAD_LOAD;
      shadow <= 8'd0;
      lzb <= 1'b0;
      seg_o <= POL;
      digit_sel_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shadow <= shadow_n;
      lzb <= lzb_n;
      seg_o <= POL ^ seg_n;
      digit_sel_o <= sel_n;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: table-driven and sequence checks of the 7-segment scanner
module tb_seg7_scan;
  localparam logic [6:0] DARK = 7'h7F;
  localparam logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct {
    logic [7:0] v;
    logic lzb;
    logic [6:0] lo;
    logic [6:0] hi;
  } vec_t;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [7:0] value_i = 8'h3A;
  logic lzb_i = 1'b0;
  logic blank_i = 1'b0;
  logic [6:0] seg_o;
  logic digit_sel_o;
  int total = 0;
  int passed = 0;
  vec_t vecs [10];
  seg7_scan #(.REFRESH_CYCLES(4), .DEAD_CYCLES(2), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .reset_i(reset_i),
    .value_i(value_i),
    .lzb_i(lzb_i),
    .blank_i(blank_i),
    .seg_o(seg_o),
    .digit_sel_o(digit_sel_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int idx, input logic [6:0] es, input logic esel);
    total++;
    if (seg_o === es && digit_sel_o === esel) passed++;
    else $display("FAIL %s[%0d]: seg=%h sel=%b expected seg=%h sel=%b", nm, idx, seg_o, digit_sel_o, es, esel);
  endtask
  task automatic run_frame(input string nm, input logic [6:0] lo, input logic [6:0] hi,
                           input logic [11:0] bmask, input int chg_at, input logic [7:0] chg_v);
    logic [6:0] es;
    for (int i = 0; i < 12; i++) begin
      blank_i = bmask[i];
      tick();
      es = bmask[i] ? DARK : i < 4 ? lo : i < 6 ? DARK : i < 10 ? hi : DARK;
      chk(nm, i, es, i >= 6);
      if (i == chg_at) value_i = chg_v;
    end
    blank_i = 1'b0;
  endtask
  initial begin
    vecs[0] = '{8'h3A, 1'b0, 7'h08, 7'h30};
    vecs[1] = '{8'h07, 1'b1, 7'h78, 7'h7F};
    vecs[2] = '{8'h07, 1'b0, 7'h78, 7'h40};
    vecs[3] = '{8'h12, 1'b0, 7'h24, 7'h79};
    vecs[4] = '{8'hF0, 1'b1, 7'h40, 7'h0E};
    vecs[5] = '{8'h00, 1'b1, 7'h40, 7'h7F};
    vecs[6] = '{8'hBC, 1'b0, 7'h46, 7'h03};
    vecs[7] = '{8'hD9, 1'b0, 7'h10, 7'h21};
    vecs[8] = '{8'h8E, 1'b0, 7'h06, 7'h00};
    vecs[9] = '{8'h56, 1'b0, 7'h02, 7'h12};
    tick();
    tick();
    chk("reset", 0, DARK, 1'b0);
    reset_i = 1'b0;
    tick();
    chk("startup_dead", 1, DARK, 1'b0);
    run_frame("startup", 8'h08, 7'h30, 12'h000, -1, 8'h00);
    run_frame("startup_rpt", 8'h08, 7'h30, 12'h000, -1, 8'h00);
    for (int k = 0; k < 10; k++) begin
      value_i = vecs[k].v;
      lzb_i = vecs[k].lzb;
      run_frame("vec", vecs[k].lo, vecs[k].hi, 12'h000, -1, 8'h00);
    end
    lzb_i = 1'b0;
    value_i = 8'h12;
    run_frame("latch_hold", 7'h24, 7'h79, 12'h000, 7, 8'h34);
    run_frame("latch_next", 7'h19, 7'h30, 12'h000, -1, 8'h00);
    value_i = 8'h3A;
    run_frame("blank", 7'h08, 7'h30, 12'h007, -1, 8'h00);
    run_frame("blank_after", 7'h08, 7'h30, 12'h000, -1, 8'h00);
    value_i = 8'h56;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_reset_hi", 7, 7'h12, 1'b1);
    reset_i = 1'b1;
    tick();
    chk("rst_abort", 0, DARK, 1'b0);
    reset_i = 1'b0;
    value_i = 8'h3A;
    tick();
    chk("rst_dead", 1, DARK, 1'b0);
    run_frame("rst_restart", 7'h08, 7'h30, 12'h000, -1, 8'h00);
    for (int v = 0; v < 256; v++) begin
      value_i = 8'(v);
      run_frame("sweep", ~GL[v % 16], ~GL[v / 16], 12'h000, -1, 8'h00);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Downstream display stage for the iCEBreaker build: consumes the 8-bit `display_o` byte from `processor` and drives the dual-digit 7-segment PMOD. Ones nibble shows on the right digit, tens nibble on the left, with hexadecimal glyphs. The two digits are time-multiplexed with a blanked dead-time between them to suppress ghosting. The displayed value is latched once per frame so a digit pair never tears mid-scan.

## Interface
Parameters:
- `REFRESH_CYCLES`, 12000: cycles each digit is lit per frame (1 ms at 12 MHz); must be ≥1.
- `DEAD_CYCLES`, 64: blanked cycles after each digit; must be ≥1.
- `ACTIVE_LOW`, 1: 1 = segment outputs driven low to light.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `value_i`  in  8  byte to display; [3:0] ones digit, [7:4] tens digit.
- `lzb_i`  in  1  leading-zero blank: tens digit dark when latched [7:4]==0.
- `blank_i`  in  1  force all segments dark.
- `seg_o`  out  7  {g,f,e,d,c,b,a}, polarity per `ACTIVE_LOW`.
- `digit_sel_o`  out  1  0 = ones (right) digit, 1 = tens (left) digit.

## Operation
- FSM states: SHOW_LO → DEAD_A → SHOW_HI → DEAD_B → SHOW_LO.
- One down-counter, width `$clog2(max(REFRESH_CYCLES, DEAD_CYCLES))+1`. Reloaded on every state entry: `REFRESH_CYCLES-1` for SHOW states, `DEAD_CYCLES-1` for DEAD states. The state advances on the edge where the counter is 0.
- Frame period = 2·(REFRESH_CYCLES+DEAD_CYCLES) cycles. Each state lasts exactly its parameter count.
- Shadow latch: `value_i` and `lzb_i` are sampled only on the DEAD_B→SHOW_LO edge. Changes to either input at any other time are invisible until the next frame.
- Decode, logical active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - When `ACTIVE_LOW`=1, `seg_o` is the bitwise inverse of the pattern.
- "Dark" means logical 00: `seg_o`=7F when `ACTIVE_LOW`=1, 00 otherwise.
- All outputs are registered and update on the same edge as the state change:
  - SHOW_LO: `digit_sel_o`=0; `seg_o`=decode(shadow[3:0]).
  - SHOW_HI: `digit_sel_o`=1; `seg_o`=decode(shadow[7:4]), or dark if the latched lzb is 1 and shadow[7:4]==0.
  - DEAD_A/DEAD_B: `seg_o` dark; `digit_sel_o` holds its previous value. The select only changes while segments are dark.
- `blank_i`: while 1, `seg_o` is dark on the next edge regardless of state. The FSM and counter keep running and digit select keeps toggling. The shadow still latches on schedule.

## Timing
- Reset (`reset_i` high at an edge): state=DEAD_B, counter=`DEAD_CYCLES-1`, shadow=00, latched lzb=0, `seg_o` dark, `digit_sel_o`=0. This takes priority over everything else.
- After reset deasserts: `DEAD_CYCLES` dark cycles, then SHOW_LO begins with `value_i` sampled on that edge.
- Latency: a value present on the frame-boundary edge appears on `seg_o` in the same cycle it is sampled (registered output). Worst-case latency from a `value_i` change is one frame period.
- `blank_i` to `seg_o` dark: 1 cycle. Release: the segment pattern returns on the next edge if in a SHOW state.
- Reset mid-frame aborts immediately to the reset state. No partial digit is shown afterwards.
- `value_i` changing on the sampling edge itself: the value present at that edge is used.

## Test plan
Benches use `REFRESH_CYCLES`=4, `DEAD_CYCLES`=2, `ACTIVE_LOW`=1.
- **Reset/startup:** hold `value_i`=0x3A and release reset → 2 cycles with `seg_o`=7F, `digit_sel_o`=0; then 4 cycles `seg_o`=~77=08, sel 0; 2 cycles 7F; 4 cycles `seg_o`=~4F=30, sel 1; period 12 cycles repeating.
- **Frame latch:** change `value_i` 0x12→0x34 in mid-SHOW_HI → that digit keeps showing 1 (~06=79). The next SHOW_LO shows 4 (~66=19).
- **Leading-zero blank:** `value_i`=0x07, `lzb_i`=1 → SHOW_HI `seg_o`=7F with sel 1. With `lzb_i`=0 the tens digit shows 0 (~3F=40).
- **Blank:** assert `blank_i` for 3 cycles in SHOW_LO → `seg_o`=7F from the next edge. FSM timing is unchanged: the period is still 12 cycles.
- **Mid-frame reset:** pulse `reset_i` during SHOW_HI → next edge `seg_o`=7F, sel 0, then the startup sequence from scenario 1 repeats exactly.
- **All glyphs:** sweep `value_i` 0x00..0xFF, one frame each → every nibble matches the decode table on both digits, and `digit_sel_o` never changes while `seg_o` is lit.
